atm_ctrl_p: RTL and testbench
=============================

ATM_CTRL_P -- requirements
Module: atm_ctrl_p

Interface
REQ-001 SHALL have parameter NUM_ACCTS, 16, account table depth (AW = clog2(NUM_ACCTS)).
REQ-002 SHALL have parameter ACCT_W, 16, account number width.
REQ-003 SHALL have parameter PIN_W, 8, PIN width.
REQ-004 SHALL have parameter BAL_W, 16, balance width.
REQ-005 SHALL have parameter MAX_TRIES, 3, consecutive wrong PINs before account lock.
REQ-006 SHALL have parameter MIN_BAL, 'h500, minimum residual balance after withdrawal.
REQ-007 SHALL have parameter MAX_WDL, 'h4000, per-transaction withdrawal limit.
REQ-008 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-009 SHALL have provisioning ports: prov_we in 1; prov_addr in AW; prov_data in ACCT_W+PIN_W+BAL_W, {acct,pin,bal}.
REQ-010 SHALL have request ports: req_valid in 1; req_ready out 1; req_op in 2 (0 CARD, 1 PIN, 2 TXN, 3 END); req_acct in ACCT_W; req_pin in PIN_W; req_txn in 2 (0 BALANCE, 1 WITHDRAW, 2 DEPOSIT); req_amt in BAL_W.
REQ-011 SHALL have response ports: rsp_valid out 1; rsp_code out 3 (0 OK, 1 NO_ACCT, 2 BAD_PIN, 3 LOCKED, 4 LIMIT, 5 NSF, 6 OVFL, 7 SEQ_ERR); rsp_bal out BAL_W; session out 1.

Function
REQ-012 States: IDLE, SEARCH, AUTH, MENU, EXEC, RESP; req_ready SHALL be 1 only in IDLE, AUTH, MENU; request accepted on req_valid&&req_ready.
REQ-013 Each accepted request SHALL produce exactly one single-cycle rsp_valid pulse; no new acceptance until that pulse has occurred.
REQ-014 CARD in IDLE: SEARCH scans one entry per cycle from index 0, skipping invalid entries; first match -> rsp next cycle; no match after NUM_ACCTS cycles -> NO_ACCT, back to IDLE.
REQ-015 Match on locked entry SHALL respond LOCKED, return to IDLE; otherwise OK, latch index, clear try counter, enter AUTH, session=1.
REQ-016 PIN in AUTH: equal -> OK, MENU; unequal -> increment tries, BAD_PIN, stay AUTH; reaching MAX_TRIES -> set lock bit, LOCKED, IDLE.
REQ-017 TXN in MENU SHALL respond one cycle after EXEC (2 cycles after acceptance), return to MENU.
REQ-018 BALANCE: OK, rsp_bal = stored balance, no table write.
REQ-019 WITHDRAW: amt > MAX_WDL -> LIMIT; else bal < amt+MIN_BAL (computed BAL_W+1 bits) -> NSF; else bal -= amt, OK; rejects leave balance unchanged.
REQ-020 DEPOSIT: bal+amt computed BAL_W+1 bits; carry -> OVFL, unchanged; else update, OK.
REQ-021 rsp_bal SHALL carry the post-operation balance for every response after CARD success; 0 otherwise.
REQ-022 END in AUTH or MENU -> OK, IDLE, session=0; END in IDLE -> OK.
REQ-023 Any op not listed for the current state, or req_txn=3, SHALL respond SEQ_ERR with state unchanged.
REQ-024 prov_we SHALL write the entry, set its valid bit, clear its lock bit, any cycle; if coincident with an EXEC write to the same index, provisioning wins and the TXN responds SEQ_ERR.

Reset
REQ-025 rst SHALL force IDLE, req_ready=1 next cycle, rsp_valid=0, rsp_code=0, rsp_bal=0, session=0, try counter 0, clear all valid and lock bits; table data not cleared.
REQ-026 rst mid-search or mid-EXEC SHALL abort with no response and no table write.

Structure
REQ-027 Package atm_pkg SHALL hold state enum, op, txn and response-code constants.
REQ-028 Sub-module atm_acct_table SHALL hold data, valid and lock arrays with provisioning-priority write arbitration.

Verification
REQ-029 Provision idx5 {1234,'hA5,'h2000}; CARD 1234 -> OK at 7 cycles after accept; PIN A5 -> OK; BALANCE -> OK, rsp_bal 'h2000.
REQ-030 WITHDRAW 'h1000 -> OK bal 'h1000; WITHDRAW 'h0C00 -> NSF bal 'h1000; WITHDRAW 'h4001 -> LIMIT.
REQ-031 Three wrong PINs -> BAD_PIN, BAD_PIN, LOCKED; re-CARD -> LOCKED; reprovision -> CARD OK.
REQ-032 CARD unknown 9999 -> NO_ACCT after NUM_ACCTS cycles; TXN in IDLE -> SEQ_ERR.
REQ-033 Balance 'hFFF0, DEPOSIT 'h20 -> OVFL, bal 'hFFF0; DEPOSIT 'hF -> OK 'hFFFF.
REQ-034 rst during SEARCH -> no rsp_valid, IDLE, req_ready=1; prov_we coincident with EXEC same index -> SEQ_ERR, provisioned value retained.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared FSM state, request op, transaction type and
// response code constants for the ATM controller.
package atm_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_AUTH   = 3'd2;
    localparam logic [2:0] S_MENU   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] OP_CARD = 2'd0;
    localparam logic [1:0] OP_PIN  = 2'd1;
    localparam logic [1:0] OP_TXN  = 2'd2;
    localparam logic [1:0] OP_END  = 2'd3;

    localparam logic [1:0] TXN_BAL = 2'd0;
    localparam logic [1:0] TXN_WDL = 2'd1;
    localparam logic [1:0] TXN_DEP = 2'd2;

    localparam logic [2:0] RC_OK     = 3'd0;
    localparam logic [2:0] RC_NOACCT = 3'd1;
    localparam logic [2:0] RC_BADPIN = 3'd2;
    localparam logic [2:0] RC_LOCKED = 3'd3;
    localparam logic [2:0] RC_LIMIT  = 3'd4;
    localparam logic [2:0] RC_NSF    = 3'd5;
    localparam logic [2:0] RC_OVFL   = 3'd6;
    localparam logic [2:0] RC_SEQ    = 3'd7;

    function automatic logic state_ready(input logic [2:0] s);
        return (s == S_IDLE) || (s == S_AUTH) || (s == S_MENU);
    endfunction

endpackage

// File: rtl/atm_acct_table.sv
// atm_acct_table: account store with valid/lock bits; a provisioning
// write always overrides a same-cycle balance update to that entry.
module atm_acct_table #(
    parameter int NUM_ACCTS = 16,
    parameter int ACCT_W    = 16,
    parameter int PIN_W     = 8,
    parameter int BAL_W     = 16,
    localparam int AW = $clog2(NUM_ACCTS),
    localparam int DW = ACCT_W + PIN_W + BAL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prov_we,
    input  logic [AW-1:0]     prov_addr,
    input  logic [DW-1:0]     prov_data,
    input  logic              upd_we,
    input  logic [AW-1:0]     upd_idx,
    input  logic [BAL_W-1:0]  upd_bal,
    input  logic              lock_set,
    input  logic [AW-1:0]     lock_idx,
    input  logic [AW-1:0]     scan_idx,
    output logic              scan_valid,
    output logic              scan_lock,
    output logic [ACCT_W-1:0] scan_acct,
    output logic [BAL_W-1:0]  scan_bal,
    input  logic [AW-1:0]     cur_idx,
    output logic [PIN_W-1:0]  cur_pin,
    output logic [BAL_W-1:0]  cur_bal,
    output logic              conflict
);

    logic [DW-1:0]        mem [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] vld;
    logic [NUM_ACCTS-1:0] lck;

    assign conflict   = prov_we && upd_we && (prov_addr == upd_idx);

    assign scan_valid = vld[scan_idx];
    assign scan_lock  = lck[scan_idx];
    assign scan_acct  = mem[scan_idx][DW-1 -: ACCT_W];
    assign scan_bal   = mem[scan_idx][BAL_W-1:0];
    assign cur_pin    = mem[cur_idx][BAL_W +: PIN_W];
    assign cur_bal    = mem[cur_idx][BAL_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            lck <= '0;
        end else begin
            if (lock_set)
                lck[lock_idx] <= 1'b1;
            if (prov_we) begin
                vld[prov_addr] <= 1'b1;
                lck[prov_addr] <= 1'b0;
            end
        end
    end

    // data survives reset; only the valid/lock bits are cleared
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (upd_we && !conflict)
                mem[upd_idx][BAL_W-1:0] <= upd_bal;
            if (prov_we)
                mem[prov_addr] <= prov_data;
        end
    end

endmodule

// File: rtl/atm_ctrl_p.sv
// atm_ctrl_p: ATM session controller -- card lookup by linear scan,
// PIN check with lockout, and balance/withdraw/deposit transactions.
module atm_ctrl_p
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS = 16,
    parameter int ACCT_W    = 16,
    parameter int PIN_W     = 8,
    parameter int BAL_W     = 16,
    parameter int MAX_TRIES = 3,
    parameter int MIN_BAL   = 'h500,
    parameter int MAX_WDL   = 'h4000,
    localparam int AW = $clog2(NUM_ACCTS),
    localparam int DW = ACCT_W + PIN_W + BAL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prov_we,
    input  logic [AW-1:0]     prov_addr,
    input  logic [DW-1:0]     prov_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [1:0]        req_txn,
    input  logic [BAL_W-1:0]  req_amt,
    output logic              rsp_valid,
    output logic [2:0]        rsp_code,
    output logic [BAL_W-1:0]  rsp_bal,
    output logic              session
);

    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int BW1 = BAL_W + 1;
    localparam logic [TW-1:0]  MAXT = TW'(MAX_TRIES);
    localparam logic [BAL_W:0] MINB = BW1'(MIN_BAL);
    localparam logic [BAL_W:0] MAXW = BW1'(MAX_WDL);
    localparam logic [AW-1:0]  LAST = AW'(NUM_ACCTS - 1);

    logic [2:0]        state;
    logic [2:0]        ret;
    logic [AW-1:0]     sidx;
    logic [AW-1:0]     cur;
    logic [TW-1:0]     tries;
    logic [ACCT_W-1:0] acct_r;
    logic [1:0]        txn_r;
    logic [BAL_W-1:0]  amt_r;

    logic              scan_valid;
    logic              scan_lock;
    logic [ACCT_W-1:0] scan_acct;
    logic [BAL_W-1:0]  scan_bal;
    logic [PIN_W-1:0]  cur_pin;
    logic [BAL_W-1:0]  cur_bal;
    logic              conflict;

    logic              acc;
    logic              scan_hit;
    logic              pin_ok;
    logic              lock_set;
    logic              upd_we;
    logic [TW-1:0]     tries_inc;
    logic [BAL_W:0]    wneed;
    logic [BAL_W:0]    dsum;

    logic              ex_we;
    logic [2:0]        ex_code;
    logic [BAL_W-1:0]  ex_new;
    logic [2:0]        ex_code_f;
    logic [BAL_W-1:0]  ex_bal_f;

    assign req_ready = state_ready(state);
    assign rsp_valid = (state == S_RESP);
    assign acc       = req_valid && req_ready;
    assign scan_hit  = scan_valid && (scan_acct == acct_r);
    assign pin_ok    = (req_pin == cur_pin);
    assign tries_inc = tries + TW'(1);
    assign lock_set  = acc && (state == S_AUTH) && (req_op == OP_PIN)
                     && !pin_ok && (tries_inc == MAXT);

    // both limit checks are done one bit wider so nothing wraps
    assign wneed = {1'b0, amt_r} + MINB;
    assign dsum  = {1'b0, cur_bal} + {1'b0, amt_r};

    always_comb begin
        ex_we   = 1'b0;
        ex_code = RC_OK;
        ex_new  = cur_bal;
        if (txn_r == TXN_WDL) begin
            if ({1'b0, amt_r} > MAXW) begin
                ex_code = RC_LIMIT;
            end else if ({1'b0, cur_bal} < wneed) begin
                ex_code = RC_NSF;
            end else begin
                ex_we  = 1'b1;
                ex_new = cur_bal - amt_r;
            end
        end else if (txn_r == TXN_DEP) begin
            if (dsum[BAL_W]) begin
                ex_code = RC_OVFL;
            end else begin
                ex_we  = 1'b1;
                ex_new = dsum[BAL_W-1:0];
            end
        end else if (txn_r != TXN_BAL) begin
            ex_code = RC_SEQ;
        end
    end

    assign upd_we    = (state == S_EXEC) && ex_we;
    assign ex_code_f = conflict ? RC_SEQ : ex_code;
    assign ex_bal_f  = conflict ? prov_data[BAL_W-1:0] : ex_new;

    atm_acct_table #(
        .NUM_ACCTS (NUM_ACCTS),
        .ACCT_W    (ACCT_W),
        .PIN_W     (PIN_W),
        .BAL_W     (BAL_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .prov_we    (prov_we),
        .prov_addr  (prov_addr),
        .prov_data  (prov_data),
        .upd_we     (upd_we),
        .upd_idx    (cur),
        .upd_bal    (ex_new),
        .lock_set   (lock_set),
        .lock_idx   (cur),
        .scan_idx   (sidx),
        .scan_valid (scan_valid),
        .scan_lock  (scan_lock),
        .scan_acct  (scan_acct),
        .scan_bal   (scan_bal),
        .cur_idx    (cur),
        .cur_pin    (cur_pin),
        .cur_bal    (cur_bal),
        .conflict   (conflict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ret      <= S_IDLE;
            sidx     <= '0;
            cur      <= '0;
            tries    <= '0;
            acct_r   <= '0;
            txn_r    <= '0;
            amt_r    <= '0;
            rsp_code <= RC_OK;
            rsp_bal  <= '0;
            session  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc) begin
                    state   <= S_RESP;
                    ret     <= S_IDLE;
                    rsp_bal <= '0;
                    if (req_op == OP_CARD) begin
                        acct_r <= req_acct;
                        sidx   <= '0;
                        state  <= S_SEARCH;
                    end else begin
                        rsp_code <= (req_op == OP_END) ? RC_OK : RC_SEQ;
                    end
                end
                S_SEARCH: begin
                    if (scan_hit) begin
                        state <= S_RESP;
                        if (scan_lock) begin
                            rsp_code <= RC_LOCKED;
                            rsp_bal  <= '0;
                            ret      <= S_IDLE;
                        end else begin
                            rsp_code <= RC_OK;
                            rsp_bal  <= scan_bal;
                            ret      <= S_AUTH;
                            cur      <= sidx;
                            tries    <= '0;
                            session  <= 1'b1;
                        end
                    end else if (sidx == LAST) begin
                        state    <= S_RESP;
                        rsp_code <= RC_NOACCT;
                        rsp_bal  <= '0;
                        ret      <= S_IDLE;
                    end else begin
                        sidx <= sidx + AW'(1);
                    end
                end
                S_AUTH: if (acc) begin
                    state    <= S_RESP;
                    ret      <= S_AUTH;
                    rsp_bal  <= cur_bal;
                    rsp_code <= RC_SEQ;
                    if (req_op == OP_PIN) begin
                        if (pin_ok) begin
                            rsp_code <= RC_OK;
                            ret      <= S_MENU;
                        end else if (tries_inc == MAXT) begin
                            rsp_code <= RC_LOCKED;
                            ret      <= S_IDLE;
                            tries    <= '0;
                            session  <= 1'b0;
                        end else begin
                            rsp_code <= RC_BADPIN;
                            tries    <= tries_inc;
                        end
                    end else if (req_op == OP_END) begin
                        rsp_code <= RC_OK;
                        ret      <= S_IDLE;
                        session  <= 1'b0;
                    end
                end
                S_MENU: if (acc) begin
                    state    <= S_RESP;
                    ret      <= S_MENU;
                    rsp_bal  <= cur_bal;
                    rsp_code <= RC_SEQ;
                    if (req_op == OP_TXN) begin
                        txn_r <= req_txn;
                        amt_r <= req_amt;
                        state <= S_EXEC;
                    end else if (req_op == OP_END) begin
                        rsp_code <= RC_OK;
                        ret      <= S_IDLE;
                        session  <= 1'b0;
                    end
                end
                S_EXEC: begin
                    rsp_code <= ex_code_f;
                    rsp_bal  <= ex_bal_f;
                    ret      <= S_MENU;
                    state    <= S_RESP;
                end
                S_RESP: state <= ret;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ctrl_p.sv
// tb_atm_ctrl_p: directed and random requests against a behavioural
// account/session model; checks codes, balances, latency and session.
module tb_atm_ctrl_p;

    localparam int N    = 16;
    localparam int MAXT = 3;
    localparam int MINB = 'h500;
    localparam int MAXW = 'h4000;

    localparam int C_OK = 0, C_NOACCT = 1, C_BADPIN = 2, C_LOCKED = 3;
    localparam int C_LIMIT = 4, C_NSF = 5, C_OVFL = 6, C_SEQ = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prov_we = 1'b0;
    logic [3:0]  prov_addr = '0;
    logic [39:0] prov_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [15:0] req_acct = '0;
    logic [7:0]  req_pin = '0;
    logic [1:0]  req_txn = '0;
    logic [15:0] req_amt = '0;
    logic        rsp_valid;
    logic [2:0]  rsp_code;
    logic [15:0] rsp_bal;
    logic        session;

    int checks = 0;
    int errors = 0;

    int m_acct [N];
    int m_pin  [N];
    int m_bal  [N];
    bit m_vld  [N];
    bit m_lck  [N];
    int phase = 0;
    int cur   = 0;
    int tries = 0;

    int pool [4] = '{1234, 777, 4242, 3131};

    atm_ctrl_p dut (
        .clk       (clk),
        .rst       (rst),
        .prov_we   (prov_we),
        .prov_addr (prov_addr),
        .prov_data (prov_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_acct  (req_acct),
        .req_pin   (req_pin),
        .req_txn   (req_txn),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_code  (rsp_code),
        .rsp_bal   (rsp_bal),
        .session   (session)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_lck[i] = 1'b0;
        end
        phase = 0;
        tries = 0;
    endfunction

    task automatic model(input int op, input int acct, input int pin,
                         input int txn, input int amt, output int ecode,
                         output int ebal, output int elat);
        ecode = C_SEQ;
        ebal  = 0;
        elat  = 1;
        if (phase == 0) begin
            if (op == 0) begin
                ecode = C_NOACCT;
                elat  = N + 1;
                for (int i = 0; i < N; i++) begin
                    if (m_vld[i] && m_acct[i] == acct) begin
                        elat = i + 2;
                        if (m_lck[i]) begin
                            ecode = C_LOCKED;
                        end else begin
                            ecode = C_OK;
                            ebal  = m_bal[i];
                            phase = 1;
                            cur   = i;
                            tries = 0;
                        end
                        break;
                    end
                end
            end else if (op == 3) begin
                ecode = C_OK;
            end
        end else if (phase == 1) begin
            ebal = m_bal[cur];
            if (op == 1) begin
                if (pin == m_pin[cur]) begin
                    ecode = C_OK;
                    phase = 2;
                end else begin
                    tries++;
                    if (tries == MAXT) begin
                        ecode      = C_LOCKED;
                        m_lck[cur] = 1'b1;
                        phase      = 0;
                    end else begin
                        ecode = C_BADPIN;
                    end
                end
            end else if (op == 3) begin
                ecode = C_OK;
                phase = 0;
            end
        end else begin
            ebal = m_bal[cur];
            if (op == 2) begin
                elat = 2;
                if (txn == 0) begin
                    ecode = C_OK;
                end else if (txn == 1) begin
                    if (amt > MAXW)
                        ecode = C_LIMIT;
                    else if (m_bal[cur] < amt + MINB)
                        ecode = C_NSF;
                    else begin
                        m_bal[cur] = m_bal[cur] - amt;
                        ecode = C_OK;
                    end
                end else if (txn == 2) begin
                    if (m_bal[cur] + amt > 'hFFFF)
                        ecode = C_OVFL;
                    else begin
                        m_bal[cur] = m_bal[cur] + amt;
                        ecode = C_OK;
                    end
                end
                ebal = m_bal[cur];
            end else if (op == 3) begin
                ecode = C_OK;
                phase = 0;
            end
        end
    endtask

    task automatic prov(input int idx, input int a, input int p, input int b);
        @(negedge clk);
        prov_we   = 1'b1;
        prov_addr = 4'(idx);
        prov_data = {16'(a), 8'(p), 16'(b)};
        @(negedge clk);
        prov_we   = 1'b0;
        m_acct[idx] = a;
        m_pin[idx]  = p;
        m_bal[idx]  = b;
        m_vld[idx]  = 1'b1;
        m_lck[idx]  = 1'b0;
    endtask

    // coll: provision the session entry with cbal during the EXEC cycle
    task automatic do_req(input int op, input int acct, input int pin,
                          input int txn, input int amt, input bit coll,
                          input int cbal);
        int ecode, ebal, elat, lat, w, ci;
        logic [2:0]  gcode;
        logic [15:0] gbal;
        bit seen;
        ci = cur;
        model(op, acct, pin, txn, amt, ecode, ebal, elat);
        if (coll) begin
            ecode     = C_SEQ;
            ebal      = cbal;
            m_bal[ci] = cbal;
            m_vld[ci] = 1'b1;
            m_lck[ci] = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_acct  = 16'(acct);
        req_pin   = 8'(pin);
        req_txn   = 2'(txn);
        req_amt   = 16'(amt);
        w = 0;
        while (!req_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        seen  = 1'b0;
        lat   = 0;
        gcode = '0;
        gbal  = '0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                if (coll) begin
                    prov_we   = 1'b1;
                    prov_addr = 4'(ci);
                    prov_data = {16'(m_acct[ci]), 8'(m_pin[ci]), 16'(cbal)};
                end
            end else if (k == 2) begin
                prov_we = 1'b0;
            end
            if (rsp_valid) begin
                seen  = 1'b1;
                lat   = k;
                gcode = rsp_code;
                gbal  = rsp_bal;
            end
        end
        prov_we = 1'b0;
        if (!seen) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("code", 32'(gcode), 32'(ecode));
        chk("bal", 32'(gbal), 32'(ebal));
        chk("latency", 32'(lat), 32'(elat));
        chk("session", 32'(session), 32'(phase != 0));
        @(negedge clk);
        chk("pulse_len", 32'(rsp_valid), 32'd0);
    endtask

    int rnd_amt;
    int op, a, p, t;
    bit bad;

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_code", 32'(rsp_code), 32'd0);
        chk("rst_bal", 32'(rsp_bal), 32'd0);
        chk("rst_session", 32'(session), 32'd0);

        prov(5, 1234, 'hA5, 'h2000);
        do_req(0, 1234, 0, 0, 0, 0, 0);
        do_req(1, 0, 'hA5, 0, 0, 0, 0);
        do_req(2, 0, 0, 0, 0, 0, 0);
        do_req(2, 0, 0, 1, 'h1000, 0, 0);
        do_req(2, 0, 0, 1, 'h0C00, 0, 0);
        do_req(2, 0, 0, 1, 'h4001, 0, 0);
        do_req(3, 0, 0, 0, 0, 0, 0);

        do_req(0, 1234, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            do_req(1, 0, 'h00, 0, 0, 0, 0);
        do_req(0, 1234, 0, 0, 0, 0, 0);
        prov(5, 1234, 'hA5, 'h2000);
        do_req(0, 1234, 0, 0, 0, 0, 0);
        do_req(3, 0, 0, 0, 0, 0, 0);

        do_req(0, 9999, 0, 0, 0, 0, 0);
        do_req(2, 0, 0, 0, 0, 0, 0);
        do_req(3, 0, 0, 0, 0, 0, 0);

        prov(3, 777, 'h11, 'hFFF0);
        do_req(0, 777, 0, 0, 0, 0, 0);
        do_req(1, 0, 'h11, 0, 0, 0, 0);
        do_req(2, 0, 0, 2, 'h20, 0, 0);
        do_req(2, 0, 0, 2, 'h0F, 0, 0);
        do_req(2, 0, 0, 1, 'h100, 1, 'h3000);
        do_req(2, 0, 0, 0, 0, 0, 0);
        do_req(2, 0, 0, 3, 0, 0, 0);
        do_req(1, 0, 'h11, 0, 0, 0, 0);
        do_req(3, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_acct  = 16'd9999;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid)
                bad = 1'b1;
        end
        chk("rst_search_norsp", 32'(bad), 32'd0);
        chk("rst_search_ready", 32'(req_ready), 32'd1);
        chk("rst_search_sess", 32'(session), 32'd0);
        do_req(0, 1234, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++)
            prov($urandom_range(0, N - 1), pool[$urandom_range(0, 3)],
                 $urandom_range(0, 255), $urandom_range(0, 'hFFFF));

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0)
                prov($urandom_range(0, N - 1), pool[$urandom_range(0, 3)],
                     $urandom_range(0, 255), $urandom_range(0, 'hFFFF));
            op = $urandom_range(0, 3);
            a  = pool[$urandom_range(0, 3)];
            p  = $urandom_range(0, 255);
            t  = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: rnd_amt = $urandom_range(0, 'h800);
                1: rnd_amt = $urandom_range(0, 'hFFFF);
                2: rnd_amt = $urandom_range('h3FF0, 'h4010);
                default: rnd_amt = $urandom_range(0, 'h200);
            endcase
            if ($urandom_range(0, 9) < 7) begin
                if (phase == 0) begin
                    op = 0;
                    if ($urandom_range(0, 7) == 0)
                        a = 16'hBEEF;
                end else if (phase == 1) begin
                    op = 1;
                    if ($urandom_range(0, 4) != 0)
                        p = m_pin[cur];
                end else begin
                    op = ($urandom_range(0, 9) == 0) ? 3 : 2;
                end
            end
            do_req(op, a, p, t, rnd_amt, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
